// File: rtl/ds_scoreboard_if.sv
// Decode/forwarding bundle between the issue stage and the register scoreboard.
// The scoreboard takes the slave side; decode logic (or a bench) takes the master side.
interface ds_scoreboard_if #(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int NSRC   = 3,
    parameter int NSTAGE = 3
);
    logic [NSRC-1:0]      src_used;
    logic [NSRC*AW-1:0]   src_addr;
    logic [NSRC*DW-1:0]   rf_data;
    logic                 q_we;
    logic [AW-1:0]        q_dest;
    logic [NSTAGE-1:0]    stg_valid;
    logic [NSTAGE*AW-1:0] stg_dest;
    logic [NSTAGE-1:0]    stg_ready;
    logic [NSTAGE*DW-1:0] stg_data;
    logic                 issue_valid;
    logic                 issue_we;
    logic [AW-1:0]        issue_dest;
    logic                 retire_valid;
    logic                 retire_we;
    logic [AW-1:0]        retire_dest;
    logic                 flush;
    logic [NSRC*DW-1:0]   src_data;
    logic                 stall;
    logic                 busy;
    logic                 sb_err;

    modport master (
        output src_used, src_addr, rf_data, q_we, q_dest,
               stg_valid, stg_dest, stg_ready, stg_data,
               issue_valid, issue_we, issue_dest,
               retire_valid, retire_we, retire_dest, flush,
        input  src_data, stall, busy, sb_err
    );

    modport slave (
        input  src_used, src_addr, rf_data, q_we, q_dest,
               stg_valid, stg_dest, stg_ready, stg_data,
               issue_valid, issue_we, issue_dest,
               retire_valid, retire_we, retire_dest, flush,
        output src_data, stall, busy, sb_err
    );
endinterface

// File: rtl/ds_scoreboard.sv
// Register scoreboard: counts in-flight writers per register, resolves source
// operands from the youngest matching forwarding stage, and raises stall.
module ds_scoreboard #(
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int NSRC     = 3,
    parameter int NSTAGE   = 3,
    parameter int MAX_PEND = 3,
    parameter int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    ds_scoreboard_if.slave   sb
);
    localparam int NREG = 2 ** AW;

    logic [CW-1:0]   r_cnt [NREG];
    logic            r_sb_err;
    logic            w_inc_any;
    logic            w_dec_any;
    logic [NSRC-1:0] w_src_block;
    logic            w_q_full;
    logic            w_busy;

    assign w_inc_any = sb.issue_valid  && sb.issue_we  && (sb.issue_dest  != '0);
    assign w_dec_any = sb.retire_valid && sb.retire_we && (sb.retire_dest != '0);

    // NOTE: every counter, including the unused slot 0, is reset explicitly so a
    // mid-run reset discards stale pending counts rather than relying on flush.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
            r_sb_err <= 1'b0;
        end else if (sb.flush) begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                // NOTE: non-blocking updates keep every register's next value based
                // on this cycle's count, independent of loop order.
                if (w_inc_any && (sb.issue_dest == AW'(r)) &&
                    !(w_dec_any && (sb.retire_dest == AW'(r)))) begin
                    if (r_cnt[r] == CW'(MAX_PEND)) r_sb_err <= 1'b1;
                    else                           r_cnt[r] <= r_cnt[r] + 1'b1;
                end else if (w_dec_any && (sb.retire_dest == AW'(r)) &&
                             !(w_inc_any && (sb.issue_dest == AW'(r)))) begin
                    if (r_cnt[r] == '0) r_sb_err <= 1'b1;
                    else                r_cnt[r] <= r_cnt[r] - 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [AW-1:0] w_addr;
        logic          w_hazard;
        logic          w_match;
        logic          w_block;
        logic [DW-1:0] w_data;

        assign w_addr   = sb.src_addr[i*AW +: AW];
        assign w_hazard = sb.src_used[i] && (w_addr != '0) && (r_cnt[w_addr] != '0);

        // NOTE: all outputs of this block get a default first, so no path leaves
        // them unassigned and no latch is inferred.
        always_comb begin
            w_data  = sb.rf_data[i*DW +: DW];
            w_match = 1'b0;
            w_block = 1'b0;
            if (w_addr == '0) begin
                w_data = '0;
            end else if (w_hazard) begin
                // Only the youngest in-flight writer holds the correct value.
                for (int k = 0; k < NSTAGE; k++) begin
                    if (!w_match && sb.stg_valid[k] && (sb.stg_dest[k*AW +: AW] == w_addr)) begin
                        w_match = 1'b1;
                        if (sb.stg_ready[k]) w_data  = sb.stg_data[k*DW +: DW];
                        else                 w_block = 1'b1;
                    end
                end
                if (!w_match) w_block = 1'b1;
            end
        end

        assign w_src_block[i]          = w_block;
        assign sb.src_data[i*DW +: DW] = w_data;
    end

    assign w_q_full = sb.q_we && (sb.q_dest != '0) && (r_cnt[sb.q_dest] == CW'(MAX_PEND));

    always_comb begin
        w_busy = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (r_cnt[r] != '0) w_busy = 1'b1;
        end
    end

    assign sb.stall  = (|w_src_block) || w_q_full;
    assign sb.busy   = w_busy;
    assign sb.sb_err = r_sb_err;
endmodule

// File: tb/tb_ds_scoreboard.sv
// Directed bench for ds_scoreboard: forwarding priority, counter saturation,
// flush and reset behaviour, each checked against hand-computed values.
module tb_ds_scoreboard;
    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int NSRC   = 3;
    localparam int NSTAGE = 3;

    logic clk;
    logic resetn;
    int   n_pass;
    int   n_total;

    ds_scoreboard_if #(.AW(AW), .DW(DW), .NSRC(NSRC), .NSTAGE(NSTAGE)) sb ();

    ds_scoreboard #(.AW(AW), .DW(DW), .NSRC(NSRC), .NSTAGE(NSTAGE), .MAX_PEND(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic idle();
        sb.src_used = '0; sb.src_addr = '0; sb.rf_data = '0;
        sb.q_we = 1'b0; sb.q_dest = '0;
        sb.stg_valid = '0; sb.stg_dest = '0; sb.stg_ready = '0; sb.stg_data = '0;
        sb.issue_valid = 1'b0; sb.issue_we = 1'b0; sb.issue_dest = '0;
        sb.retire_valid = 1'b0; sb.retire_we = 1'b0; sb.retire_dest = '0;
        sb.flush = 1'b0;
    endtask

    task automatic set_src(input int i, input logic used, input logic [AW-1:0] addr,
                           input logic [DW-1:0] rf);
        sb.src_used[i]          = used;
        sb.src_addr[i*AW +: AW] = addr;
        sb.rf_data[i*DW +: DW]  = rf;
    endtask

    task automatic set_stg(input int k, input logic v, input logic [AW-1:0] d,
                           input logic rdy, input logic [DW-1:0] data);
        sb.stg_valid[k]         = v;
        sb.stg_dest[k*AW +: AW] = d;
        sb.stg_ready[k]         = rdy;
        sb.stg_data[k*DW +: DW] = data;
    endtask

    // Each event is held for exactly one rising edge, from one falling edge to the next.
    task automatic issue(input logic [AW-1:0] d);
        sb.issue_valid = 1'b1; sb.issue_we = 1'b1; sb.issue_dest = d;
        @(negedge clk);
        sb.issue_valid = 1'b0; sb.issue_we = 1'b0; sb.issue_dest = '0;
    endtask

    task automatic retire(input logic [AW-1:0] d);
        sb.retire_valid = 1'b1; sb.retire_we = 1'b1; sb.retire_dest = d;
        @(negedge clk);
        sb.retire_valid = 1'b0; sb.retire_we = 1'b0; sb.retire_dest = '0;
    endtask

    function automatic logic [DW-1:0] src_out(input int i);
        return sb.src_data[i*DW +: DW];
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Reset state and plain regfile passthrough
        set_src(0, 1'b1, 5'd5, 32'h0000_AAAA);
        #1;
        check("rst_busy",   32'(sb.busy),   32'd0);
        check("rst_stall",  32'(sb.stall),  32'd0);
        check("rst_err",    32'(sb.sb_err), 32'd0);
        check("rst_rfpass", src_out(0),     32'h0000_AAAA);

        // Forward from youngest ready stage
        @(negedge clk); idle();
        issue(5'd5);
        set_src(0, 1'b1, 5'd5, 32'h0000_AAAA);
        set_stg(0, 1'b1, 5'd5, 1'b1, 32'h0000_1234);
        #1;
        check("fwd_busy",  32'(sb.busy),  32'd1);
        check("fwd_data",  src_out(0),    32'h0000_1234);
        check("fwd_stall", 32'(sb.stall), 32'd0);

        // Youngest match not ready blocks even though an older stage is ready
        set_stg(0, 1'b1, 5'd5, 1'b0, 32'h0000_1234);
        set_stg(1, 1'b1, 5'd5, 1'b1, 32'h0000_5555);
        #1;
        check("young_blk", 32'(sb.stall), 32'd1);

        // Only an older stage matches: forward from it
        set_stg(0, 1'b1, 5'd6, 1'b0, 32'h0000_1234);
        set_stg(1, 1'b0, 5'd5, 1'b1, 32'h0000_5555);
        set_stg(2, 1'b1, 5'd5, 1'b1, 32'h0000_7777);
        #1;
        check("old_fwd_data",  src_out(0),    32'h0000_7777);
        check("old_fwd_stall", 32'(sb.stall), 32'd0);

        // Retire r5, then operand comes from the regfile
        @(negedge clk); idle();
        retire(5'd5);
        set_src(0, 1'b1, 5'd5, 32'h0000_BBBB);
        #1;
        check("ret5_busy",  32'(sb.busy),  32'd0);
        check("ret5_stall", 32'(sb.stall), 32'd0);
        check("ret5_data",  src_out(0),    32'h0000_BBBB);

        // Saturate r7 at three writers
        @(negedge clk); idle();
        issue(5'd7); issue(5'd7); issue(5'd7);
        sb.q_we = 1'b1; sb.q_dest = 5'd7;
        #1;
        check("full_stall", 32'(sb.stall),  32'd1);
        check("full_err0",  32'(sb.sb_err), 32'd0);
        issue(5'd7);
        #1;
        check("ovf_err",   32'(sb.sb_err), 32'd1);
        check("ovf_stall", 32'(sb.stall),  32'd1);
        sb.retire_valid = 1'b1; sb.retire_we = 1'b1; sb.retire_dest = 5'd7;
        issue(5'd7);
        sb.retire_valid = 1'b0; sb.retire_we = 1'b0; sb.retire_dest = '0;
        #1;
        check("incdec_stall", 32'(sb.stall), 32'd1);
        retire(5'd7);
        #1;
        check("cnt2_stall", 32'(sb.stall), 32'd0);
        check("cnt2_busy",  32'(sb.busy),  32'd1);
        retire(5'd7); retire(5'd7);
        #1;
        check("cnt0_busy", 32'(sb.busy), 32'd0);

        // Reset clears the sticky error
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst2_err", 32'(sb.sb_err), 32'd0);

        // Underflow sets error and keeps count at zero
        @(negedge clk); idle();
        retire(5'd2);
        #1;
        check("unf_err",  32'(sb.sb_err), 32'd1);
        check("unf_busy", 32'(sb.busy),   32'd0);

        // Writer outside forwarding window blocks until retired
        issue(5'd9);
        set_src(1, 1'b1, 5'd9, 32'h0000_9999);
        set_stg(0, 1'b1, 5'd8, 1'b1, 32'h0000_0808);
        #1;
        check("nomatch_stall", 32'(sb.stall), 32'd1);
        sb.src_used[1] = 1'b0;
        #1;
        check("unused_stall", 32'(sb.stall), 32'd0);
        sb.src_used[1] = 1'b1;
        retire(5'd9);
        #1;
        check("ret9_stall", 32'(sb.stall), 32'd0);
        check("ret9_data",  src_out(1),    32'h0000_9999);

        // Flush beats same-cycle retire; sticky error survives
        @(negedge clk); idle();
        issue(5'd3); issue(5'd4);
        #1;
        check("pre_flush_busy", 32'(sb.busy), 32'd1);
        sb.flush = 1'b1;
        retire(5'd3);
        sb.flush = 1'b0;
        #1;
        check("flush_busy", 32'(sb.busy),   32'd0);
        check("flush_err",  32'(sb.sb_err), 32'd1);
        set_src(2, 1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("r0_data",  src_out(2),    32'h0000_0000);
        check("r0_stall", 32'(sb.stall), 32'd0);

        // Register 0 is never tracked
        issue(5'd0);
        #1;
        check("r0_busy", 32'(sb.busy), 32'd0);

        // Reset overrides a same-cycle issue and discards pending counts
        issue(5'd6);
        resetn = 1'b0;
        issue(5'd6);
        resetn = 1'b1;
        set_src(0, 1'b1, 5'd6, 32'h0000_6666);
        #1;
        check("rstmid_busy",  32'(sb.busy),   32'd0);
        check("rstmid_err",   32'(sb.sb_err), 32'd0);
        check("rstmid_stall", 32'(sb.stall),  32'd0);
        check("rstmid_data",  src_out(0),     32'h0000_6666);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ds_scoreboard.md
DS_SCOREBOARD -- requirements
Module: ds_scoreboard

Interface
REQ-001 Parameters (name, default, meaning): AW, 5, register address width; DW, 32, data width; NSRC, 3, source operands queried per cycle; NSTAGE, 3, forwarding stages (index 0 = youngest); MAX_PEND, 3, max in-flight writers per register; CW = clog2(MAX_PEND+1), counter width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 src_used  in  NSRC  per-source "operand is read" flag.
REQ-005 src_addr  in  NSRC*AW  source register numbers, source i at bits [i*AW +: AW].
REQ-006 rf_data  in  NSRC*DW  regfile read data per source.
REQ-007 q_we, q_dest  in  1, AW  write intent and destination of the instruction in decode.
REQ-008 stg_valid, stg_dest, stg_ready, stg_data  in  NSTAGE, NSTAGE*AW, NSTAGE, NSTAGE*DW  per-stage writer valid, destination, result-available flag and result.
REQ-009 issue_valid, issue_we, issue_dest  in  1, 1, AW  decode instruction leaves decode this cycle.
REQ-010 retire_valid, retire_we, retire_dest  in  1, 1, AW  writeback commits an instruction this cycle.
REQ-011 flush  in  1  kill all in-flight (un-retired) instructions.
REQ-012 src_data  out  NSRC*DW  resolved operand values.
REQ-013 stall  out  1  decode must hold.
REQ-014 busy  out  1  some register has pending writers.
REQ-015 sb_err  out  1  sticky protocol-error flag.

Function
REQ-016 Per register r (1..2^AW-1), a CW-bit counter cnt[r] SHALL hold the number of issued, un-retired writers; register 0 SHALL never be tracked.
REQ-017 Issue increment when issue_valid & issue_we & issue_dest!=0; retire decrement when retire_valid & retire_we & retire_dest!=0.
REQ-018 Increment and decrement of the same register in one cycle SHALL leave cnt unchanged.
REQ-019 Increment at cnt==MAX_PEND SHALL hold cnt and set sb_err; decrement at cnt==0 SHALL hold 0 and set sb_err; no wrap-around.
REQ-020 flush SHALL clear every counter next cycle, overriding same-cycle issue/retire; it SHALL NOT clear sb_err.
REQ-021 Source i SHALL be hazardous when src_used[i] & src_addr[i]!=0 & cnt[src_addr[i]]!=0.
REQ-022 For a hazardous source, the lowest-index stage k with stg_valid[k] & stg_dest[k]==src_addr[i] is the match; if stg_ready[k], src_data[i]=stg_data[k], else the source blocks.
REQ-023 Hazardous source with no stage match SHALL block (writer outside forwarding window).
REQ-024 Non-hazardous source SHALL yield rf_data[i]; src_addr[i]==0 SHALL yield 0 regardless of rf_data.
REQ-025 stall = any source blocking, or (q_we & q_dest!=0 & cnt[q_dest]==MAX_PEND); combinational, zero latency.
REQ-026 src_data and stall SHALL depend on current inputs and registered cnt only; counter updates become visible the cycle after the causing event.
REQ-027 busy SHALL be the OR of all counters being nonzero, derived from registered state.
REQ-028 Upstream SHALL NOT assert issue_valid while stall; the block does not gate issue_valid itself.

Reset
REQ-029 resetn low at a rising edge SHALL clear all counters and sb_err; next cycle busy=0, stall=0 for any query not blocked by stage readiness, src_data=rf_data (0 for address 0).
REQ-030 Reset mid-operation SHALL discard pending counts and override flush, issue and retire in that cycle.

Verification
REQ-031 Issue we dest=5; next cycle src_addr[0]=5 with stg0 valid dest=5 ready=1 data=0x1234 -> src_data[0]=0x1234, stall=0.
REQ-032 Same, but stg0 ready=0 (load in EX), stg1 valid dest=5 ready=1 -> stall=1 (youngest match wins, no older forwarding).
REQ-033 Issue dest=7 three times, q_we q_dest=7 -> stall=1; a forced fourth issue -> cnt stays 3, sb_err=1; retire dest=7 with issue dest=7 same cycle -> cnt stays 3.
REQ-034 cnt[9]=1, no stage matches 9, src_addr=9 -> stall=1; retire dest=9 -> next cycle stall=0, src_data=rf_data.
REQ-035 Pending writers on r3,r4, flush with same-cycle retire r3 -> next cycle busy=0, sb_err unchanged; src_addr=0 with rf_data=0xFFFF_FFFF -> src_data=0.
